// File: rtl/fetch_aligner_pkg.sv
// Shared types and helpers for the instruction-fetch aligner.
package fetch_aligner_pkg;

    localparam int INSTRUCTION_WIDTH = 32;

    typedef enum logic [1:0] {
        S_WORD,
        S_HALF,
        S_SKIP
    } align_state_t;

    function automatic logic is_rvc(input logic [1:0] opc);
        return opc != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_aligner_out_reg.sv
// Single-entry valid/ready holding register for an aligned instruction and its PC.
module fetch_out_reg
    import fetch_aligner_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         load,
    input  logic [INSTRUCTION_WIDTH-1:0] load_data,
    input  logic [31:0]                  load_pc,
    input  logic                         ready,
    output logic                         valid,
    output logic [INSTRUCTION_WIDTH-1:0] data,
    output logic [31:0]                  pc,
    output logic                         slot_free
);

    assign slot_free = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_aligner.sv
// Fetch front end: word reads split into a 16/32-bit instruction stream.
// Optional rvc_count output enabled by defining ALIGN_RVC_COUNT_EN.
//
// state  | meaning
// S_WORD | next word starts on an instruction boundary
// S_HALF | residual holds the upper half of the last word
// S_SKIP | next word's low half lies before pc and is discarded
module fetch_aligner
    import fetch_aligner_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef ALIGN_RVC_COUNT_EN
    output logic [31:0]                  rvc_count,
`endif
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         mem_req_valid,
    output logic [31:0]                  mem_req_addr,
    input  logic                         mem_req_ready,
    input  logic                         mem_rsp_valid,
    input  logic [31:0]                  mem_rsp_data,
    output logic                         instr_valid,
    output logic [INSTRUCTION_WIDTH-1:0] instr_data,
    output logic [31:0]                  instr_pc,
    input  logic                         instr_ready
);

    align_state_t state, nxt_state;
    logic [15:0]  residual, nxt_residual;
    logic         outstanding;
    logic         drop;
    logic         run;
    logic [31:0]  fetch_addr;
    logic [31:0]  pc;
    logic [2:0]   pc_inc;
    logic         slot_free;
    logic         need_word;
    logic         req_fire;
    logic         rsp_use;
    logic         res_emit;
    logic         load;
    logic [INSTRUCTION_WIDTH-1:0] load_data;

    // run holds requests off until the first clock after reset release
    assign need_word     = (state != S_HALF) || !is_rvc(residual[1:0]);
    assign mem_req_valid = run && !outstanding && !redirect_valid && need_word && slot_free;
    assign mem_req_addr  = run ? fetch_addr : '0;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign rsp_use       = mem_rsp_valid && !redirect_valid && !drop;
    assign res_emit      = run && !redirect_valid && !outstanding && (state == S_HALF)
                           && is_rvc(residual[1:0]) && slot_free;

    always_comb begin
        nxt_state    = state;
        nxt_residual = residual;
        load         = 1'b0;
        load_data    = '0;
        pc_inc       = 3'd0;
        if (rsp_use) begin
            case (state)
                S_WORD: begin
                    load = 1'b1;
                    if (is_rvc(mem_rsp_data[1:0])) begin
                        load_data    = {16'b0, mem_rsp_data[15:0]};
                        pc_inc       = 3'd2;
                        nxt_residual = mem_rsp_data[31:16];
                        nxt_state    = S_HALF;
                    end else begin
                        load_data = mem_rsp_data;
                        pc_inc    = 3'd4;
                    end
                end
                S_SKIP: begin
                    nxt_residual = mem_rsp_data[31:16];
                    nxt_state    = S_HALF;
                end
                S_HALF: begin
                    load         = 1'b1;
                    load_data    = {mem_rsp_data[15:0], residual};
                    pc_inc       = 3'd4;
                    nxt_residual = mem_rsp_data[31:16];
                end
                default: nxt_state = S_WORD;
            endcase
        end else if (res_emit) begin
            load      = 1'b1;
            load_data = {16'b0, residual};
            pc_inc    = 3'd2;
            nxt_state = S_WORD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RESET_PC[1] ? S_SKIP : S_WORD;
            residual    <= '0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            run         <= 1'b0;
            fetch_addr  <= {RESET_PC[31:2], 2'b00};
            pc          <= RESET_PC;
        end else begin
            run <= 1'b1;
            if (redirect_valid) begin
                state      <= redirect_pc[1] ? S_SKIP : S_WORD;
                residual   <= '0;
                pc         <= redirect_pc & ~32'd1;
                fetch_addr <= redirect_pc & ~32'd3;
                drop       <= outstanding && !mem_rsp_valid;
                if (mem_rsp_valid)
                    outstanding <= 1'b0;
            end else begin
                if (req_fire) begin
                    outstanding <= 1'b1;
                    fetch_addr  <= fetch_addr + 32'd4;
                end else if (mem_rsp_valid) begin
                    outstanding <= 1'b0;
                    drop        <= 1'b0;
                end
                state    <= nxt_state;
                residual <= nxt_residual;
                pc       <= pc + {29'b0, pc_inc};
            end
        end
    end

    fetch_out_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .load      (load),
        .load_data (load_data),
        .load_pc   (pc),
        .ready     (instr_ready),
        .valid     (instr_valid),
        .data      (instr_data),
        .pc        (instr_pc),
        .slot_free (slot_free)
    );

`ifdef ALIGN_RVC_COUNT_EN
    // A pop in a redirect cycle still counts: the consumer took it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rvc_count <= '0;
        else if (instr_valid && instr_ready && is_rvc(instr_data[1:0]))
            rvc_count <= rvc_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner with a one-deep latency-programmable memory model.
module tb_fetch_aligner;
    import fetch_aligner_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic [INSTRUCTION_WIDTH-1:0] instr_data;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef ALIGN_RVC_COUNT_EN
    logic [31:0] rvc_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [int unsigned];
    int          rsp_lat = 1;
    logic        pend = 1'b0;
    int          pend_wait = 0;
    logic [31:0] pend_addr = '0;
    int          req_count = 0;
    logic [31:0] pop_data[$];
    logic [31:0] pop_pc[$];
    int          pop_reads[$];
    logic [31:0] req_addr_q[$];

    fetch_aligner dut (
        .clk            (clk),
        .rst            (rst),
`ifdef ALIGN_RVC_COUNT_EN
        .rvc_count      (rvc_count),
`endif
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Pops are logged with the number of reads issued before them
    initial forever begin
        @(negedge clk);
        if (!rst && !redirect_valid && instr_valid && instr_ready) begin
            pop_data.push_back(instr_data);
            pop_pc.push_back(instr_pc);
            pop_reads.push_back(req_count);
        end
        if (rst) pend = 1'b0;
        else if (mem_req_valid && mem_req_ready) begin
            req_count++;
            req_addr_q.push_back(mem_req_addr);
            pend = 1'b1;
            pend_wait = rsp_lat;
            pend_addr = mem_req_addr;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        if (rst) pend = 1'b0;
        else if (pend) begin
            if (pend_wait <= 1) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_read(pend_addr);
                pend = 1'b0;
            end else pend_wait--;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        pop_data.delete(); pop_pc.delete(); pop_reads.delete(); req_addr_q.delete();
        req_count = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        instr_ready = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        pend = 1'b0; rsp_lat = 1;
        mem.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_pops(input int n, input string name);
        int cyc = 0;
        while (pop_data.size() < n && cyc < 200) begin
            @(negedge clk); #1; cyc++;
        end
        checks++;
        if (pop_data.size() < n) begin
            errors++;
            $display("FAIL %s_timeout: pops=%0d required=%0d", name, pop_data.size(), n);
        end
    endtask

    task automatic drive_redirect(input logic [31:0] target);
        redirect_valid = 1'b1; redirect_pc = target;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;
        instr_ready = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
        checks++; if (mem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h want 0", mem_req_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
        checks++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_instr_data: got %h want 0", instr_data); end
        checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
`ifdef ALIGN_RVC_COUNT_EN
        checks++; if (rvc_count !== 32'h0) begin errors++; $display("FAIL reset_rvc_count: got %0d want 0", rvc_count); end
`endif
        do_reset();
    endtask

    task automatic test_aligned_mix();
        do_reset();
        mem[32'h0] = 32'h00A5_0513;
        mem[32'h4] = 32'h4505_0505;
        instr_ready = 1'b1;
        wait_pops(3, "aligned_mix");
        checks++; if (pop_data[0] !== 32'h00A5_0513 || pop_pc[0] !== 32'h0) begin errors++; $display("FAIL mix_i0: got %h@%h want 00a50513@0", pop_data[0], pop_pc[0]); end
        checks++; if (pop_data[1] !== 32'h0000_0505 || pop_pc[1] !== 32'h4) begin errors++; $display("FAIL mix_i1: got %h@%h want 00000505@4", pop_data[1], pop_pc[1]); end
        checks++; if (pop_data[2] !== 32'h0000_4505 || pop_pc[2] !== 32'h6) begin errors++; $display("FAIL mix_i2: got %h@%h want 00004505@6", pop_data[2], pop_pc[2]); end
        checks++; if (pop_reads[2] !== 2) begin errors++; $display("FAIL mix_reads: got %0d want 2", pop_reads[2]); end
        checks++; if (req_addr_q[1] !== 32'h4) begin errors++; $display("FAIL mix_addr1: got %h want 4", req_addr_q[1]); end
    endtask

    task automatic test_straddle();
        do_reset();
        mem[32'h0] = 32'h0513_0001;
        mem[32'h4] = 32'h0000_00A5;
        instr_ready = 1'b1;
        mem_req_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin errors++; $display("FAIL stall_req_%0d: got %b@%h want 1@0", i, mem_req_valid, mem_req_addr); end
        end
        @(posedge clk);
        #1 mem_req_ready = 1'b1;
        wait_pops(3, "straddle");
        checks++; if (pop_data[0] !== 32'h0000_0001 || pop_pc[0] !== 32'h0) begin errors++; $display("FAIL straddle_i0: got %h@%h want 00000001@0", pop_data[0], pop_pc[0]); end
        checks++; if (pop_data[1] !== 32'h00A5_0513 || pop_pc[1] !== 32'h2) begin errors++; $display("FAIL straddle_i1: got %h@%h want 00a50513@2", pop_data[1], pop_pc[1]); end
        checks++; if (pop_data[2] !== 32'h0 || pop_pc[2] !== 32'h6) begin errors++; $display("FAIL straddle_i2: got %h@%h want 00000000@6", pop_data[2], pop_pc[2]); end
        checks++; if (pop_reads[2] !== 2) begin errors++; $display("FAIL straddle_reads: got %0d want 2", pop_reads[2]); end
    endtask

    task automatic test_misaligned_redirect();
        do_reset();
        mem[32'h100] = 32'h4585_FFFF;
        drive_redirect(32'h102);
        clear_logs();
        instr_ready = 1'b1;
        wait_pops(2, "misaligned");
        checks++; if (pop_data[0] !== 32'h0000_4585 || pop_pc[0] !== 32'h102) begin errors++; $display("FAIL misaligned_i0: got %h@%h want 00004585@102", pop_data[0], pop_pc[0]); end
        checks++; if (pop_data[1] !== 32'h0 || pop_pc[1] !== 32'h104) begin errors++; $display("FAIL misaligned_i1: got %h@%h want 00000000@104", pop_data[1], pop_pc[1]); end
        checks++; if (req_addr_q[0] !== 32'h100) begin errors++; $display("FAIL misaligned_addr: got %h want 100", req_addr_q[0]); end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        do_reset();
        mem[32'h0] = 32'h00A5_0513;
        mem[32'h4] = 32'h00B5_0593;
        while (instr_valid !== 1'b1 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout: got %b want 1", instr_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (instr_valid !== 1'b1 || instr_data !== 32'h00A5_0513 || instr_pc !== 32'h0)
                begin errors++; $display("FAIL bp_hold_%0d: got %b %h@%h want 1 00a50513@0", i, instr_valid, instr_data, instr_pc); end
            checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_noreq_%0d: got %b want 0", i, mem_req_valid); end
        end
        @(posedge clk);
        #1 instr_ready = 1'b1;
        @(negedge clk);
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4) begin errors++; $display("FAIL bp_release_req: got %b@%h want 1@4", mem_req_valid, mem_req_addr); end
        wait_pops(2, "backpressure");
        checks++; if (pop_data[1] !== 32'h00B5_0593 || pop_pc[1] !== 32'h4) begin errors++; $display("FAIL bp_next: got %h@%h want 00b50593@4", pop_data[1], pop_pc[1]); end
    endtask

    task automatic test_redirect_in_flight();
        int cyc = 0;
        do_reset();
        rsp_lat = 4;
        mem[32'h10]  = 32'h1111_1113;
        mem[32'h200] = 32'h02A0_0513;
        drive_redirect(32'h10);
        clear_logs();
        instr_ready = 1'b1;
        while (req_addr_q.size() == 0 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        checks++; if (req_addr_q.size() == 0 || req_addr_q[0] !== 32'h10) begin errors++; $display("FAIL inflight_first_req: got size %0d want read@10", req_addr_q.size()); end
        @(posedge clk);
        #1 drive_redirect(32'h200);
        wait_pops(1, "inflight");
        checks++; if (pop_data[0] !== 32'h02A0_0513 || pop_pc[0] !== 32'h200) begin errors++; $display("FAIL inflight_i0: got %h@%h want 02a00513@200", pop_data[0], pop_pc[0]); end
        checks++; if (req_addr_q[1] !== 32'h200) begin errors++; $display("FAIL inflight_addr: got %h want 200", req_addr_q[1]); end
        rsp_lat = 1;
    endtask

    task automatic test_async_reset();
        int cyc = 0;
        do_reset();
        mem[32'h0] = 32'h4505_0505;
        instr_ready = 1'b1;
        wait_pops(2, "async_pre");
        @(posedge clk);
        #1 instr_ready = 1'b0;
        while (instr_valid !== 1'b1 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", instr_valid); end
        checks++; if (instr_data !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL async_data_pc: got %h@%h want 0@0", instr_data, instr_pc); end
        checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin errors++; $display("FAIL async_req: got %b@%h want 0@0", mem_req_valid, mem_req_addr); end
`ifdef ALIGN_RVC_COUNT_EN
        checks++; if (rvc_count !== 32'h0) begin errors++; $display("FAIL async_rvc_count: got %0d want 0", rvc_count); end
`endif
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        instr_ready = 1'b1;
        cyc = 0;
        while (req_addr_q.size() == 0 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        checks++; if (req_addr_q.size() == 0 || req_addr_q[0] !== 32'h0) begin errors++; $display("FAIL async_first_req: got size %0d want read@0", req_addr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_aligned_mix();
        test_straddle();
        test_misaligned_redirect();
        test_backpressure();
        test_redirect_in_flight();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_aligner.md
Name: fetch_aligner

Overview:
- Instruction-fetch front end. Issues word-aligned 32-bit memory reads and splits the returned words into a stream of 16-bit (RVC) and 32-bit instructions.
- Handles 32-bit instructions that straddle a word boundary, and redirects to halfword-aligned PCs.
- Output feeds the RVC expander: instr_data[1:0] != 2'b11 marks a compressed instruction held in bits [15:0], with bits [31:16] zero.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch PC after reset; bit 0 must be 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bit0 ignored, bit1 may be 1
- mem_req_valid  out  1  read request
- mem_req_addr  out  32  word address; bits[1:0] = 0
- mem_req_ready  in  1  memory accepts the request
- mem_rsp_valid  in  1  read data returned; arrives at least 1 cycle after acceptance
- mem_rsp_data  in  32  read data
- instr_valid  out  1  instruction available
- instr_data  out  INSTRUCTION_WIDTH  instruction (RVC zero-extended)
- instr_pc  out  32  PC of instr_data
- instr_ready  in  1  consumer accepts the instruction

Behaviour:
- **Reset (async, rst=1):**
  - mem_req_valid=0, mem_req_addr=0.
  - instr_valid=0, instr_data=0, instr_pc=0.
  - State=S_WORD, residual invalid, outstanding=0, drop=0.
  - fetch_addr={RESET_PC[31:2],2'b00}, pc=RESET_PC.
  - If RESET_PC[1]=1, state=S_SKIP.
- **Output register:** single entry. instr_valid holds, with data and PC stable, until instr_valid && instr_ready.
- **Request rule:**
  - Assert mem_req_valid when all of these hold: no request outstanding; no redirect this cycle; state needs a word (S_WORD, S_SKIP, or S_HALF with a non-RVC residual); output slot empty or popping this cycle.
  - On a mem_req_ready handshake: outstanding=1 and fetch_addr+=4.
  - At most one request is in flight.
- **Response rule:** a response clears outstanding. If drop=1, the data is discarded and drop clears. Otherwise it is processed by state:
  - S_WORD:
    - If low half is RVC: emit {16'b0, d[15:0]} at pc; residual=d[31:16]; go to S_HALF.
    - Otherwise: emit d at pc; stay in S_WORD.
  - S_SKIP: residual=d[31:16]; go to S_HALF; nothing emitted.
  - S_HALF with a non-RVC residual: emit {d[15:0], residual} at pc; residual=d[31:16]; stay in S_HALF.
- **S_HALF with an RVC residual:** when the output slot is empty or popping, emit {16'b0, residual} with no memory access, then go to S_WORD.
- **PC advance:** pc advances by 2 per RVC instruction and by 4 per 32-bit instruction, at the emit.
- **Redirect (highest priority):**
  - Clears instr_valid and the residual.
  - pc=redirect_pc & ~1; fetch_addr=redirect_pc & ~3.
  - State=S_SKIP if redirect_pc[1]=1, else S_WORD.
  - If a request is outstanding with no response this cycle, set drop=1.
  - A response arriving in the same cycle as the redirect is discarded.
  - If instr_ready was high in that cycle, the pop is still considered done; the instruction is lost by design.
- **Wrap:** fetch_addr and pc wrap modulo 2^32 without flagging.

Optional Feature:
- Macro ALIGN_RVC_COUNT_EN.
- Defined: adds an output port rvc_count (32-bit), reset to 0. It increments on each output handshake where instr_data[1:0] != 2'b11, wraps at 2^32, and is not cleared by redirect.
- Undefined: no port and no counter logic; behaviour otherwise identical.

Decomposition:
- Package common holds: INSTRUCTION_WIDTH (existing), a new typedef enum logic[1:0] align_state_t {S_WORD, S_HALF, S_SKIP}, and function is_rvc(logic[1:0]) returning the bits != 2'b11.
- One natural sub-module: fetch_out_reg, the single-entry valid/ready holding register for data+PC.

Test Plan:
- **Aligned mix:** RESET_PC=0; word 0x00A50513 (32-bit), then word 0x4505_0505 (two RVC).
  - Emits 0x00A50513@0, then 0x0505@4, then 0x4505@6.
  - Only 2 memory reads.
- **Straddle:** words 0x0513_0001, 0x0000_00A5.
  - Emits 0x0001@0, then 0x00A50513@2.
  - Residual 0x0000 is then emitted @6 without a third read.
- **Misaligned redirect:** redirect_pc=0x102; memory word@0x100=0x4585_FFFF.
  - First emit is 0x4585@0x102; the low half is never emitted.
- **Backpressure:** hold instr_ready=0 for 5 cycles with instr_valid=1.
  - Data and PC stay stable, and mem_req_valid stays 0.
  - Releasing ready produces the next request in the same cycle.
- **Redirect with a request in flight:** redirect at 0x200 while the read@0x10 is outstanding.
  - The stale response is dropped; the first emit has instr_pc=0x200.
- **Async reset mid-stream:** assert rst between clock edges.
  - Outputs clear immediately; the first post-reset request is at RESET_PC.
  - With ALIGN_RVC_COUNT_EN defined, rvc_count=0.
